tug_playfield: RTL and testbench

- Player-input and playfield side of the tug-of-war game.
- Conditions the two raw push-buttons into one-cycle press pulses and moves a single lit LED along an N-LED bar toward whichever player pressed.
- Drives the press pulses (L, R) and the edge-lit flags (leftleds, rightleds) that the downstream winner/7-seg block consumes.
- Also drives the LED bar itself.

---
 rtl/tug_playfield.sv | 107 ++++++++++
 tb/tb_tug_playfield.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: button conditioning into press pulses and a one-hot LED bar.
// Optional DEBOUNCE_EN adds a per-button stability counter of DB_CYCLES clocks.
`timescale 1ns/1ps
module tug_playfield #(
  parameter int N         = 9,
  parameter int DB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         L_in,
  input  logic         R_in,
  input  logic         hold,
  output logic         L,
  output logic         R,
  output logic [N-1:0] leds,
  output logic         leftleds,
  output logic         rightleds
);

  localparam int C  = (N - 1) / 2;
  localparam int PW = $clog2(N);

  generate
    if (N < 3 || (N % 2) != 1 || DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_params
      $error("tug_playfield: N must be odd and >= 3, DB_CYCLES must be 2..255");
    end
  endgenerate

  // Bit 1 carries the left button, bit 0 the right button throughout.
  logic [1:0] raw;
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;
  logic [1:0] level;
  logic [1:0] prev_reg;
  logic [1:0] pulse_reg;
  logic [PW-1:0] pos_reg;

  assign raw = {L_in, R_in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef DEBOUNCE_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      logic [7:0] cnt_reg;
      logic       level_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (sync2_reg[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == 8'(DB_CYCLES - 1)) begin
          level_reg <= sync2_reg[gi];
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end

      assign level[gi] = level_reg;
    end
  endgenerate
`else
  assign level = sync2_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_reg  <= '0;
      pulse_reg <= '0;
    end else begin
      prev_reg  <= level;
      pulse_reg <= level & ~prev_reg;
    end
  end

  assign L = pulse_reg[1];
  assign R = pulse_reg[0];

  // Moves act on the pulse cycle; hold still lets pulses through to the scorer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_reg <= PW'(C);
    end else if (!hold) begin
      if (pulse_reg == 2'b10 && pos_reg < PW'(N - 1))
        pos_reg <= pos_reg + PW'(1);
      else if (pulse_reg == 2'b01 && pos_reg > PW'(0))
        pos_reg <= pos_reg - PW'(1);
    end
  end

  assign leds      = N'(1) << pos_reg;
  assign leftleds  = leds[N-1];
  assign rightleds = leds[0];

endmodule

// File: tb/tb_tug_playfield.sv
// Self-checking bench for tug_playfield: vector table, directed corners, random vs reference model.
`timescale 1ns/1ps
module tb_tug_playfield;
  localparam int N = 9;
  localparam int C = 4;

  logic clk = 1'b0, reset = 1'b0, L_in = 1'b0, R_in = 1'b0, hold = 1'b0;
  logic L, R, leftleds, rightleds;
  logic [N-1:0] leds;

  tug_playfield #(.N(N), .DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .L_in(L_in), .R_in(R_in), .hold(hold),
    .L(L), .R(R), .leds(leds), .leftleds(leftleds), .rightleds(rightleds)
  );

  always #5 clk = ~clk;

  int nvec = 0, nbad = 0, cyc = 0;
  bit use_model = 1'b0;

  // Reference model: pulse = sampled level two edges ago and not three edges ago.
  int pos_m;
  bit exp_l, exp_r;
  bit ql[$], qr[$];

  function automatic void model_reset();
    pos_m = C; exp_l = 1'b0; exp_r = 1'b0;
    ql = '{1'b0, 1'b0, 1'b0, 1'b0};
    qr = '{1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic void model_edge(bit l, bit r, bit h);
    if (!h && exp_l && !exp_r) pos_m = (pos_m < N - 1) ? pos_m + 1 : pos_m;
    else if (!h && exp_r && !exp_l) pos_m = (pos_m > 0) ? pos_m - 1 : pos_m;
    ql.push_front(l); void'(ql.pop_back());
    qr.push_front(r); void'(qr.pop_back());
    exp_l = ql[2] & ~ql[3];
    exp_r = qr[2] & ~qr[3];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nbad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  task automatic chk_model();
    logic [N-1:0] el;
    el = N'(1) << pos_m;
    chk("model L", 32'(L), 32'(exp_l));
    chk("model R", 32'(R), 32'(exp_r));
    chk("model leds", 32'(leds), 32'(el));
    chk("model leftleds", 32'(leftleds), 32'(pos_m == N - 1));
    chk("model rightleds", 32'(rightleds), 32'(pos_m == 0));
  endtask

  task automatic step(input logic l, input logic r, input logic h);
    L_in = l; R_in = r; hold = h;
    @(posedge clk);
    model_edge(l, r, h);
    cyc++;
    #1;
    if (use_model) chk_model();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " leds"}, 32'(leds), 32'h010);
    chk({nm, " L"}, 32'(L), 32'd0);
    chk({nm, " R"}, 32'(R), 32'd0);
    chk({nm, " leftleds"}, 32'(leftleds), 32'd0);
    chk({nm, " rightleds"}, 32'(rightleds), 32'd0);
  endtask

  // Assert reset between edges, check the outputs react at once, release after a negedge.
  task automatic async_reset();
    #2 reset = 1'b0;
    L_in = 1'b0; R_in = 1'b0; hold = 1'b0;
    #1 chk_reset_vals("async reset");
    model_reset();
    @(posedge clk); cyc++;
    @(negedge clk); reset = 1'b1;
  endtask

  typedef struct {
    logic l, r, h;
    logic el, er;
    logic [N-1:0] eleds;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic l, input logic r, input logic h,
                     input logic el, input logic er, input logic [N-1:0] ld);
    for (int i = 0; i < n; i++) tbl.push_back('{l, r, h, el, er, ld});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, at;
    logic lit;
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("power-on reset");
    @(negedge clk); reset = 1'b1;

`ifndef DEBOUNCE_EN
    use_model = 1'b1;
    add(10, 0, 0, 0, 0, 0, 9'b000010000);
    add(2,  1, 0, 0, 0, 0, 9'b000010000);
    add(1,  1, 0, 0, 1, 0, 9'b000010000);
    add(5,  1, 0, 0, 0, 0, 9'b000100000);
    add(2,  0, 0, 0, 0, 0, 9'b000100000);
    add(2,  1, 1, 0, 0, 0, 9'b000100000);
    add(1,  1, 1, 0, 1, 1, 9'b000100000);
    add(1,  1, 1, 0, 0, 0, 9'b000100000);
    add(2,  0, 0, 0, 0, 0, 9'b000100000);
    add(2,  0, 1, 1, 0, 0, 9'b000100000);
    add(1,  0, 1, 1, 0, 1, 9'b000100000);
    add(2,  0, 0, 1, 0, 0, 9'b000100000);
    add(2,  0, 0, 0, 0, 0, 9'b000100000);
    add(2,  0, 1, 0, 0, 0, 9'b000100000);
    add(1,  0, 1, 0, 0, 1, 9'b000100000);
    add(2,  0, 0, 0, 0, 0, 9'b000010000);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].l, tbl[i].r, tbl[i].h);
      chk($sformatf("tbl[%0d] L", i), 32'(L), 32'(tbl[i].el));
      chk($sformatf("tbl[%0d] R", i), 32'(R), 32'(tbl[i].er));
      chk($sformatf("tbl[%0d] leds", i), 32'(leds), 32'(tbl[i].eleds));
    end

    // Left saturation: five separate presses from the centre.
    for (int p = 1; p <= 5; p++) begin
      pulses = 0; lit = 1'b0;
      for (int j = 0; j < 6; j++) begin
        step(j < 3, 1'b0, 1'b0);
        if (L) begin pulses++; lit = leftleds; end
      end
      chk($sformatf("sat press %0d pulses", p), 32'(pulses), 32'd1);
      chk($sformatf("sat press %0d leds", p), 32'(leds), 32'(9'b1 << ((C + p > N - 1) ? N - 1 : C + p)));
      if (p >= 4) chk($sformatf("sat press %0d leftleds", p), 32'(leftleds), 32'd1);
      if (p == 5) chk("sat 5th pulse with left lit", 32'(lit), 32'd1);
    end

    // Right edge, then reset during a further press.
    async_reset();
    for (int p = 1; p <= 4; p++)
      for (int j = 0; j < 6; j++) step(1'b0, j < 3, 1'b0);
    chk("right edge leds", 32'(leds), 32'h001);
    chk("right edge rightleds", 32'(rightleds), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    async_reset();
    pulses = 0;
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 1'b0, 1'b0);
      if (R) pulses++;
    end
    chk("no R after reset", 32'(pulses), 32'd0);
    chk("leds after reset", 32'(leds), 32'h010);

    // Randomized run against the reference model, with occasional async resets.
    begin
      logic rl, rr;
      rl = 1'b0; rr = 1'b0;
      for (int i = 0; i < 1200; i++) begin
        if ($urandom_range(0, 99) < 30) rl = ~rl;
        if ($urandom_range(0, 99) < 30) rr = ~rr;
        step(rl, rr, $urandom_range(0, 9) == 0);
        if ($urandom_range(0, 299) == 0) begin
          async_reset(); rl = 1'b0; rr = 1'b0;
        end
      end
    end
`else
    // Two-cycle glitch must be filtered out.
    pulses = 0;
    for (int j = 0; j < 14; j++) begin
      step(j < 2, 1'b0, 1'b0);
      chk("db onehot", 32'($onehot(leds)), 32'd1);
      if (L) pulses++;
    end
    chk("db glitch pulses", 32'(pulses), 32'd0);
    chk("db glitch leds", 32'(leds), 32'h010);
    // Long press: one pulse at 2+4 cycles after sampling, then one step left.
    pulses = 0; at = -1;
    for (int j = 0; j < 16; j++) begin
      step(j < 10, 1'b0, 1'b0);
      chk("db onehot", 32'($onehot(leds)), 32'd1);
      if (L) begin pulses++; at = j; end
    end
    chk("db press pulses", 32'(pulses), 32'd1);
    chk("db press latency", 32'(at), 32'd6);
    chk("db press leds", 32'(leds), 32'h020);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
